// File: rtl/mux_arbiter.sv
// Two-channel output arbiter. Channels A and B compete for ownership of a
// shared mux output. Both requesting from IDLE grants the channel that was
// not served last. An owner keeps the grant for up to BURST transfers. On
// release, ownership goes straight to a waiting channel with no IDLE cycle.
module mux_arbiter #(
  parameter int unsigned BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       ack,
  output logic       s,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic [3:0] xfer_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  // The counter is widened by one bit so that comparing it against a BURST
  // of 15 cannot wrap.
  localparam logic [4:0] BURST_W = 5'(BURST);

  state_t     state;
  state_t     state_nxt;
  logic       last_a;
  logic       last_a_nxt;
  logic       s_nxt;
  logic [3:0] cnt_nxt;
  logic       own_req;
  logic       oth_req;
  logic       xfer;
  logic [4:0] cnt_inc;
  logic       burst_done;

  // State, grants, select and counter are all flops, so every output is
  // registered. The last-served flag resets to B so that the first contested
  // grant goes to A.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      s        <= 1'b0;
      xfer_cnt <= 4'd0;
      last_a   <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt_a    <= (state_nxt == OWN_A);
      gnt_b    <= (state_nxt == OWN_B);
      s        <= s_nxt;
      xfer_cnt <= cnt_nxt;
      last_a   <= last_a_nxt;
    end
  end

  // Next-state logic. A transfer counts only when the owner is still
  // requesting and ack is high. The owner is released when it drops its
  // request or when it completes its last allowed transfer.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = xfer_cnt;
    last_a_nxt = last_a;
    s_nxt      = s;
    own_req    = (state == OWN_A) ? req_a : req_b;
    oth_req    = (state == OWN_A) ? req_b : req_a;
    xfer       = own_req && ack;
    cnt_inc    = {1'b0, xfer_cnt} + 5'd1;
    burst_done = xfer && (cnt_inc == BURST_W);

    case (state)
      IDLE: begin
        cnt_nxt = 4'd0;
        if (req_a && req_b) begin
          state_nxt = last_a ? OWN_B : OWN_A;
        end else if (req_a) begin
          state_nxt = OWN_A;
        end else if (req_b) begin
          state_nxt = OWN_B;
        end
      end
      OWN_A, OWN_B: begin
        if (!own_req || burst_done) begin
          cnt_nxt = 4'd0;
          if (oth_req) begin
            state_nxt = (state == OWN_A) ? OWN_B : OWN_A;
          end else if (own_req) begin
            state_nxt = state;
          end else begin
            state_nxt = IDLE;
          end
        end else if (xfer) begin
          cnt_nxt = cnt_inc[3:0];
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase

    if (state_nxt == OWN_A) begin
      last_a_nxt = 1'b1;
      s_nxt      = 1'b1;
    end else if (state_nxt == OWN_B) begin
      last_a_nxt = 1'b0;
      s_nxt      = 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Randomized and directed scoreboard bench for mux_arbiter. It drives two
// instances from the same stimulus: one with BURST=4 and one with BURST=1.
module tb_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a;
  logic       req_b;
  logic       ack;
  logic       s4, ga4, gb4;
  logic       s1, ga1, gb1;
  logic [3:0] cnt4, cnt1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    bit       ga[2];
    bit       gb[2];
    bit       sel[2];
    int       cnt[2];
  } exp_t;

  exp_t scoreboard[$];

  // Reference model. owner: 0 = none, 1 = A, 2 = B. last: 1 = A, 2 = B.
  int bursts[2] = '{4, 1};
  int m_owner[2];
  int m_cnt[2];
  int m_last[2];
  bit m_sel[2];
  bit started = 1'b0;

  mux_arbiter #(.BURST(4)) dut4 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .ack(ack),
    .s(s4), .gnt_a(ga4), .gnt_b(gb4), .xfer_cnt(cnt4)
  );

  mux_arbiter #(.BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .ack(ack),
    .s(s1), .gnt_a(ga1), .gnt_b(gb1), .xfer_cnt(cnt1)
  );

  always #5 clk = ~clk;

  // Apply the arbitration rules for one cycle of the given inputs.
  task automatic modelStep(input int i, input bit r, input bit ra, input bit rb, input bit ak);
    int who;
    bit mine, other;
    int done;
    if (r) begin
      m_owner[i] = 0; m_cnt[i] = 0; m_last[i] = 2; m_sel[i] = 1'b0;
      return;
    end
    if (m_owner[i] == 0) begin
      if (ra && rb) who = (m_last[i] == 1) ? 2 : 1;
      else if (ra)  who = 1;
      else if (rb)  who = 2;
      else          who = 0;
      m_cnt[i] = 0;
      if (who != 0) begin
        m_owner[i] = who;
        m_last[i]  = who;
      end
    end else begin
      mine  = (m_owner[i] == 1) ? ra : rb;
      other = (m_owner[i] == 1) ? rb : ra;
      done  = m_cnt[i] + ((mine && ak) ? 1 : 0);
      if (!mine || done == bursts[i]) begin
        m_cnt[i] = 0;
        if (other) m_owner[i] = 3 - m_owner[i];
        else if (!mine) m_owner[i] = 0;
        m_last[i] = (m_owner[i] == 0) ? m_last[i] : m_owner[i];
      end else begin
        m_cnt[i] = done;
      end
    end
    if (m_owner[i] == 1) m_sel[i] = 1'b1;
    if (m_owner[i] == 2) m_sel[i] = 1'b0;
  endtask

  // Drive one cycle of inputs, step the model and queue the expected outputs.
  task automatic applyStimulus(input bit r, input bit ra, input bit rb, input bit ak);
    exp_t e;
    @(negedge clk);
    rst = r; req_a = ra; req_b = rb; ack = ak;
    for (int i = 0; i < 2; i++) begin
      modelStep(i, r, ra, rb, ak);
      e.ga[i]  = (m_owner[i] == 1);
      e.gb[i]  = (m_owner[i] == 2);
      e.sel[i] = m_sel[i];
      e.cnt[i] = m_cnt[i];
    end
    scoreboard.push_back(e);
    started = 1'b1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
  endtask

  // Monitor: after each rising edge, compare both instances against the
  // oldest queued expectation and check the grant invariants.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      checkOutput("b4_gnt_a", int'(ga4), int'(e.ga[0]));
      checkOutput("b4_gnt_b", int'(gb4), int'(e.gb[0]));
      checkOutput("b4_s", int'(s4), int'(e.sel[0]));
      checkOutput("b4_xfer_cnt", int'(cnt4), e.cnt[0]);
      checkOutput("b1_gnt_a", int'(ga1), int'(e.ga[1]));
      checkOutput("b1_gnt_b", int'(gb1), int'(e.gb[1]));
      checkOutput("b1_s", int'(s1), int'(e.sel[1]));
      checkOutput("b1_xfer_cnt", int'(cnt1), e.cnt[1]);
    end
    if (started) begin
      checkOutput("b4_mutex", int'(ga4 & gb4), 0);
      checkOutput("b1_mutex", int'(ga1 & gb1), 0);
      checkOutput("b4_cnt_le_burst", int'(cnt4 <= 4'd4), 1);
      checkOutput("b1_cnt_le_burst", int'(cnt1 <= 4'd1), 1);
    end
  end

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; ack = 1'b0;

    // Reset, then both requesting with ack held high.
    repeat (2) applyStimulus(1, 0, 0, 0);
    repeat (14) applyStimulus(0, 1, 1, 1);

    // Only B requests while ack toggles.
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < 14; k++) applyStimulus(0, 0, 1, (k % 2) == 0);

    // A drops its request after two transfers, with B idle.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 1);
    repeat (2) applyStimulus(0, 1, 0, 1);
    repeat (3) applyStimulus(0, 0, 0, 1);

    // Reset in the middle of a B grant, then both request.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 1);
    repeat (2) applyStimulus(0, 0, 1, 1);
    applyStimulus(1, 1, 1, 1);
    repeat (4) applyStimulus(0, 1, 1, 1);

    // Random traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      applyStimulus($urandom_range(0, 59) == 0,
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) != 0);
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", scoreboard.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter BURST, default 4, maximum transfers per grant (legal 1..15).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req_a  input  1  channel A (mux input a) requests ownership of mux output.
REQ-005 req_b  input  1  channel B (mux input b) requests ownership of mux output.
REQ-006 ack  input  1  downstream accepts current mux output word this cycle.
REQ-007 s  output  1  mux select; 1 routes a to y, 0 routes b to y.
REQ-008 gnt_a  output  1  channel A owns the output.
REQ-009 gnt_b  output  1  channel B owns the output.
REQ-010 xfer_cnt  output  4  transfers completed in current grant.

Function
REQ-011 States SHALL be IDLE, OWN_A and OWN_B; gnt_a=1 only in OWN_A, gnt_b=1 only in OWN_B.
REQ-012 All outputs SHALL be registered; gnt_a and gnt_b SHALL never both be 1.
REQ-013 A transfer SHALL be a cycle with gnt_x=1, req_x=1 and ack=1; ack in any other cycle SHALL be ignored.
REQ-014 s SHALL be 1 in OWN_A, 0 in OWN_B, and SHALL hold its previous value in IDLE.
REQ-015 Internal last-served flag SHALL record the channel of the most recent grant.
REQ-016 IDLE: one requester -> grant it next cycle; both -> grant the channel not last served; none -> stay IDLE.
REQ-017 Request-to-grant latency from IDLE SHALL be exactly 1 cycle.
REQ-018 In OWN_X, each transfer SHALL increment xfer_cnt by 1; xfer_cnt SHALL clear to 0 on every new grant and in IDLE.
REQ-019 Release SHALL occur when req_x=0 in a granted cycle, or on the transfer that makes xfer_cnt reach BURST.
REQ-020 On release, if the other channel requests, ownership SHALL pass to it next cycle with no IDLE gap.
REQ-021 On burst release with the other channel idle and req_x=1, channel X SHALL be re-granted next cycle with xfer_cnt=0.
REQ-022 On release with no pending requests, next state SHALL be IDLE.
REQ-023 Release with req_x=0 and transfer count below BURST SHALL not re-grant X even if req_x rises that same cycle; re-evaluation occurs from IDLE.
REQ-024 BURST=1 SHALL release after every transfer, alternating channels when both request.
REQ-025 xfer_cnt SHALL never exceed BURST and SHALL not wrap.

Reset
REQ-026 rst=1 SHALL force next cycle: state IDLE, gnt_a=0, gnt_b=0, s=0, xfer_cnt=0, last-served=B.
REQ-027 rst asserted mid-grant SHALL drop grant on next edge regardless of req/ack; rst SHALL override all other inputs.
REQ-028 First grant after reset with both requesting SHALL go to A.

Verification
REQ-029 Reset, then req_a=req_b=1, ack=1 constant, BURST=4 -> gnt_a 1 cycle after release of rst, s=1, xfer_cnt 0..3, then gnt_b with s=0 next cycle, alternating every 4 transfers.
REQ-030 req_b only, ack toggling 1/0 -> gnt_b held, xfer_cnt increments only on ack=1 cycles, re-granted B with xfer_cnt=0 after 4th transfer.
REQ-031 In OWN_A drop req_a after 2 transfers while req_b=0 -> IDLE next cycle, gnt_a=0, s stays 1, xfer_cnt=0.
REQ-032 Assert rst during OWN_B with xfer_cnt=2 -> next cycle gnts 0, s=0, xfer_cnt=0; with both requesting afterwards, A granted first.
REQ-033 BURST=1, both requesting, ack=1 -> gnt alternates A,B,A,B every cycle, xfer_cnt always 0 at grant.
REQ-034 All scenarios -> checker confirms gnt_a&gnt_b never 1 and xfer_cnt<=BURST every cycle.
